hssi_traffic_gen_mc: RTL and testbench
======================================

// Module: hssi_traffic_gen_mc
// PURPOSE
//  Multi-channel HSSI packet traffic generator; one independent AXI-S TX stream per channel.
//  Runtime config per channel: packet count, fixed/random length, incremental/random data.
//  Sits between the CSR block (config/start/status) and the HSSI TX AXI-S ports of the loopback test path.
// PARAMETERS
//  NUM_CH      4            number of independent channels
//  DATA_W      64           tdata width in bits, multiple of 8; BYTES=DATA_W/8
//  LEN_W       14           packet length field width (bytes)
//  MIN_LEN     64           minimum generated packet length (bytes)
//  LFSR_SEED   32'hACE1_2468  base LFSR seed; channel c uses LFSR_SEED ^ c
// PORTS
//  clk              in   1               clock
//  rst_n            in   1               async active-low reset
//  cfg_start        in   NUM_CH          per-channel start pulse
//  cfg_stop         in   NUM_CH          per-channel stop pulse
//  cfg_num_pkt      in   NUM_CH*32       packets to send; 0 = continuous until stop
//  cfg_len_type     in   NUM_CH          0 fixed length, 1 random length
//  cfg_pattern      in   NUM_CH          0 incremental data, 1 random data
//  cfg_pkt_len      in   NUM_CH*LEN_W    fixed length, or max length when random
//  tx_tvalid        out  NUM_CH          AXI-S valid
//  tx_tdata         out  NUM_CH*DATA_W   AXI-S data, byte 0 in bits [7:0]
//  tx_tkeep         out  NUM_CH*BYTES    AXI-S byte enables
//  tx_tlast         out  NUM_CH          end of packet
//  tx_tready        in   NUM_CH          AXI-S ready
//  st_busy          out  NUM_CH          channel in LOAD/SEND
//  st_done          out  NUM_CH          sticky done; cleared by next accepted start
//  st_pkt_cnt       out  NUM_CH*32       packets completed since start (tlast handshakes)
// BEHAVIOUR
//  - Reset (async assert, sync deassert via rst_n): all outputs 0, FSMs IDLE, LFSRs = seed. Reset mid-packet drops tvalid immediately; no tlast is emitted.
//  - Per-channel FSM: IDLE -> LOAD -> SEND -> DONE.
//    IDLE: cfg_start -> LOAD; all cfg_* sampled into shadow regs; st_done, st_pkt_cnt cleared.
//    LOAD (1 cycle): compute packet length L; remaining beats = ceil(L/BYTES) -> SEND.
//    SEND: tvalid=1. Beat advances only on tvalid&tready. On tlast handshake: pkt_cnt++.
//      If pkt_cnt==num_pkt (num_pkt!=0) or stop pending -> DONE; else -> LOAD.
//    DONE: st_done=1, busy=0; cfg_start -> LOAD (restart).
//  - First tvalid is 2 cycles after the start pulse. There is 1 idle cycle (LOAD) between packets.
//  - cfg_start while busy is ignored. cfg_stop in LOAD/SEND is latched and finishes the current packet; a packet is never truncated. cfg_stop in IDLE/DONE is ignored. Start and stop in the same cycle from IDLE: start wins, stop is ignored.
//  - Length: fixed L = max(cfg_pkt_len, MIN_LEN). Random L = min(max(cfg_pkt_len,MIN_LEN), MIN_LEN + lfsr[10:0]); LFSR advances once per LOAD.
//  - tkeep = all ones except on the last beat, where r = L mod BYTES; r==0 -> all ones, else low r bits set. tkeep is 0 when tvalid=0.
//  - Data, incremental: byte k of the packet = k[7:0]; wraps at 256; restarts at 0 each packet.
//  - Data, random: separate 32-bit data LFSR (x^32+x^22+x^2+x+1) per channel, replicated across DATA_W; advances per accepted beat.
//  - Length LFSR uses the same polynomial with seed ^ 32'h5A5A_5A5A.
//  - AXI-S: tdata/tkeep/tlast held stable while tvalid & !tready. tvalid never drops mid-packet except on reset.
//  - st_pkt_cnt wraps at 2^32 in continuous mode.
//  - Channels are fully independent; no shared state.
// TESTING
//  T1 ch0 fixed, num_pkt=0x20, len=0x42, DATA_W=64, tready=1 -> 32 pkts x 9 beats, last tkeep=8'h03, bytes 0x00..0x41; st_done=1, st_pkt_cnt=32.
//  T2 T1 with tready random 50% -> byte stream identical to T1; tdata/tkeep/tlast stable during stalls.
//  T3 random len, cfg_pkt_len=1500, num_pkt=1000 -> every L in [64,1500]; tkeep consistent with L; all tlast counted.
//  T4 num_pkt=0, stop asserted mid-packet 5 -> packet 5 completes, st_pkt_cnt=6, DONE; cfg_pkt_len=10 -> L=64.
//  T5 4 channels, mixed modes, independent tready -> per-channel streams match the reference model; start on ch2 while busy ignored.
//  T6 rst_n low mid-packet -> tvalid=0 same cycle; after release, start -> clean packet beginning with byte 0.

Source files
------------

// File: rtl/hssi_traffic_gen_mc.sv
// Multi-channel AXI-Stream packet generator for the HSSI loopback path.
// Each channel runs its own IDLE/LOAD/SEND/DONE sequencer with private length and data LFSRs.
module hssi_traffic_gen_mc #(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 64,
    parameter int          LEN_W     = 14,
    parameter int          MIN_LEN   = 64,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            cfg_start,
    input  logic [NUM_CH-1:0]            cfg_stop,
    input  logic [NUM_CH*32-1:0]         cfg_num_pkt,
    input  logic [NUM_CH-1:0]            cfg_len_type,
    input  logic [NUM_CH-1:0]            cfg_pattern,
    input  logic [NUM_CH*LEN_W-1:0]      cfg_pkt_len,
    output logic [NUM_CH-1:0]            tx_tvalid,
    output logic [NUM_CH*DATA_W-1:0]     tx_tdata,
    output logic [NUM_CH*(DATA_W/8)-1:0] tx_tkeep,
    output logic [NUM_CH-1:0]            tx_tlast,
    input  logic [NUM_CH-1:0]            tx_tready,
    output logic [NUM_CH-1:0]            st_busy,
    output logic [NUM_CH-1:0]            st_done,
    output logic [NUM_CH*32-1:0]         st_pkt_cnt
);

    localparam int          BYTES        = DATA_W / 8;
    localparam int          LW1          = LEN_W + 1;
    localparam logic [31:0] LEN_SEED_XOR = 32'h5A5A_5A5A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, shifting toward the MSB
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [31:0] DATA_SEED = LFSR_SEED ^ 32'(c);
        localparam logic [31:0] LEN_SEED  = DATA_SEED ^ LEN_SEED_XOR;

        state_t            state_q, state_d;
        logic [31:0]       num_pkt_q, pkt_cnt_q, len_lfsr_q, data_lfsr_q;
        logic [LEN_W-1:0]  pkt_len_q, beats_q;
        logic              len_type_q, pattern_q, stop_q;
        logic [BYTES-1:0]  last_keep_q;
        logic [7:0]        byte_ofs_q;

        logic              start, stop, ready, valid, last_beat, hs, finish;
        logic [LEN_W-1:0]  base_len, rand_cap, new_len, new_beats, new_rem;
        logic [BYTES-1:0]  new_keep, tkeep;
        logic [DATA_W-1:0] tdata;

        assign start     = cfg_start[c];
        assign stop      = cfg_stop[c];
        assign ready     = tx_tready[c];
        assign valid     = (state_q == S_SEND);
        assign last_beat = (beats_q == LEN_W'(1));
        assign hs        = valid & ready;

        always_comb begin : len_calc
            base_len  = (pkt_len_q < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : pkt_len_q;
            rand_cap  = LEN_W'(MIN_LEN) + LEN_W'(len_lfsr_q[10:0]);
            new_len   = (len_type_q && (rand_cap < base_len)) ? rand_cap : base_len;
            new_beats = LEN_W'(({1'b0, new_len} + LW1'(BYTES - 1)) / LW1'(BYTES));
            new_rem   = new_len % LEN_W'(BYTES);
            new_keep  = '0;
            for (int unsigned j = 0; j < BYTES; j++) begin
                new_keep[j] = (new_rem == '0) || (LEN_W'(j) < new_rem);
            end
        end

        always_comb begin : fsm_next
            state_d = state_q;
            finish  = 1'b0;
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_LOAD;
                S_LOAD:         state_d = S_SEND;
                S_SEND: begin
                    if (hs && last_beat) begin
                        // a stop arriving on the tlast beat itself still ends the run
                        finish  = stop_q || stop ||
                                  ((num_pkt_q != '0) && (pkt_cnt_q + 32'd1 == num_pkt_q));
                        state_d = finish ? S_DONE : S_LOAD;
                    end
                end
                default:        state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin : state_reg
            if (!rst_n) state_q <= S_IDLE;
            else        state_q <= state_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
            if (!rst_n) begin
                num_pkt_q   <= '0;
                pkt_cnt_q   <= '0;
                pkt_len_q   <= '0;
                len_type_q  <= 1'b0;
                pattern_q   <= 1'b0;
                stop_q      <= 1'b0;
                beats_q     <= '0;
                last_keep_q <= '0;
                byte_ofs_q  <= '0;
                len_lfsr_q  <= LEN_SEED;
                data_lfsr_q <= DATA_SEED;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            num_pkt_q  <= cfg_num_pkt[c*32 +: 32];
                            pkt_len_q  <= cfg_pkt_len[c*LEN_W +: LEN_W];
                            len_type_q <= cfg_len_type[c];
                            pattern_q  <= cfg_pattern[c];
                            pkt_cnt_q  <= '0;
                            stop_q     <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        beats_q     <= new_beats;
                        last_keep_q <= new_keep;
                        byte_ofs_q  <= '0;
                        len_lfsr_q  <= lfsr_step(len_lfsr_q);
                        stop_q      <= stop_q | stop;
                    end
                    S_SEND: begin
                        stop_q <= stop_q | stop;
                        if (hs) begin
                            beats_q     <= beats_q - LEN_W'(1);
                            byte_ofs_q  <= byte_ofs_q + 8'(BYTES);
                            data_lfsr_q <= lfsr_step(data_lfsr_q);
                            if (last_beat) pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin : beat_out
            tdata = '0;
            tkeep = '0;
            if (valid) begin
                for (int unsigned j = 0; j < BYTES; j++) begin
                    tdata[8*j +: 8] = pattern_q ? data_lfsr_q[8*(j%4) +: 8]
                                                : byte_ofs_q + 8'(j);
                end
                tkeep = last_beat ? last_keep_q : '1;
            end
        end

        assign tx_tvalid[c]                   = valid;
        assign tx_tlast[c]                    = valid & last_beat;
        assign tx_tdata[c*DATA_W +: DATA_W]   = tdata;
        assign tx_tkeep[c*BYTES +: BYTES]     = tkeep;
        assign st_busy[c]                     = (state_q == S_LOAD) || (state_q == S_SEND);
        assign st_done[c]                     = (state_q == S_DONE);
        assign st_pkt_cnt[c*32 +: 32]         = pkt_cnt_q;
    end

endmodule

// File: tb/tb_hssi_traffic_gen_mc.sv
// Self-checking bench for hssi_traffic_gen_mc: a packet model fills per-channel
// expected-beat queues at start time; a negedge monitor pops them on each handshake.
module tb_hssi_traffic_gen_mc;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 14;
    localparam int BYTES  = DATA_W / 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        cfg_start, cfg_stop, cfg_len_type, cfg_pattern;
    logic [NUM_CH*32-1:0]     cfg_num_pkt;
    logic [NUM_CH*LEN_W-1:0]  cfg_pkt_len;
    logic [NUM_CH-1:0]        tx_tvalid, tx_tlast, tx_tready;
    logic [NUM_CH*DATA_W-1:0] tx_tdata;
    logic [NUM_CH*BYTES-1:0]  tx_tkeep;
    logic [NUM_CH-1:0]        st_busy, st_done;
    logic [NUM_CH*32-1:0]     st_pkt_cnt;

    hssi_traffic_gen_mc #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .MIN_LEN  (64),
        .LFSR_SEED(32'hACE1_2468)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_num_pkt (cfg_num_pkt),
        .cfg_len_type(cfg_len_type),
        .cfg_pattern (cfg_pattern),
        .cfg_pkt_len (cfg_pkt_len),
        .tx_tvalid   (tx_tvalid),
        .tx_tdata    (tx_tdata),
        .tx_tkeep    (tx_tkeep),
        .tx_tlast    (tx_tlast),
        .tx_tready   (tx_tready),
        .st_busy     (st_busy),
        .st_done     (st_done),
        .st_pkt_cnt  (st_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  keep;
        logic              last;
        int unsigned       plen;
    } beat_t;

    typedef struct {
        int          ch;
        int unsigned num;
        bit          lt;
        bit          pat;
        int unsigned len;
        int unsigned rdy;
        int          stop_at;
        int unsigned exp_cnt;
        int          budget;
    } vec_t;

    beat_t       exp_q [NUM_CH][$];
    logic [31:0] m_dlfsr [NUM_CH];
    logic [31:0] m_llfsr [NUM_CH];
    int unsigned m_num [NUM_CH];
    int unsigned m_len [NUM_CH];
    int unsigned m_sent [NUM_CH];
    int unsigned byte_cnt [NUM_CH];
    int unsigned rdy_pct [NUM_CH];
    bit          m_lt [NUM_CH];
    bit          m_pat [NUM_CH];
    bit          m_stop [NUM_CH];
    bit          m_active [NUM_CH];
    bit          prev_stall [NUM_CH];
    logic [DATA_W+BYTES+1:0] prev_vec [NUM_CH];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input int ch,
                                  input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ch%0d: got %0h expected %0h", name, ch, act, exp);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    function automatic void push_pkt(input int c);
        int unsigned L, cap, beats, r;
        logic [31:0] d;
        beat_t e;
        L = (m_len[c] < 64) ? 64 : m_len[c];
        if (m_lt[c]) begin
            cap = 64 + (m_llfsr[c] & 32'h7FF);
            if (cap < L) L = cap;
        end
        m_llfsr[c] = step(m_llfsr[c]);
        beats = (L + 7) / 8;
        r = L % 8;
        for (int unsigned b = 0; b < beats; b++) begin
            d = m_dlfsr[c];
            for (int j = 0; j < BYTES; j++)
                e.data[8*j +: 8] = m_pat[c] ? d[8*(j%4) +: 8] : 8'((b*8 + j) & 255);
            e.keep = (b == beats - 1 && r != 0) ? BYTES'((1 << r) - 1) : '1;
            e.last = (b == beats - 1);
            e.plen = L;
            m_dlfsr[c] = step(m_dlfsr[c]);
            exp_q[c].push_back(e);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_dlfsr[c]  = 32'hACE1_2468 ^ 32'(c);
            m_llfsr[c]  = (32'hACE1_2468 ^ 32'(c)) ^ 32'h5A5A_5A5A;
            exp_q[c].delete();
            m_active[c] = 1'b0;
            m_sent[c]   = 0;
            m_stop[c]   = 1'b0;
            byte_cnt[c] = 0;
        end
    endfunction

    function automatic void model_start(input int c, input int unsigned num, input bit lt,
                                        input bit pat, input int unsigned len);
        if (!m_active[c]) begin
            m_num[c] = num; m_lt[c] = lt; m_pat[c] = pat; m_len[c] = len;
            m_sent[c] = 0; m_stop[c] = 1'b0; m_active[c] = 1'b1; byte_cnt[c] = 0;
            push_pkt(c);
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input int c, input int unsigned num, input bit lt,
                           input bit pat, input int unsigned len);
        cfg_num_pkt[c*32 +: 32]       = num;
        cfg_len_type[c]               = lt;
        cfg_pattern[c]                = pat;
        cfg_pkt_len[c*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic drive_start(input int c, input int unsigned num, input bit lt,
                               input bit pat, input int unsigned len);
        set_cfg(c, num, lt, pat, len);
        cfg_start[c] = 1'b1;
        model_start(c, num, lt, pat, len);
        cyc(1);
        cfg_start[c] = 1'b0;
    endtask

    task automatic wait_done(input int c, input int budget, input int unsigned exp_cnt);
        int k = 0;
        while (!st_done[c] && k < budget) begin
            cyc(1);
            k++;
        end
        check("st_done", c, st_done[c], 1'b1);
        check("st_busy_done", c, st_busy[c], 1'b0);
        check("st_pkt_cnt", c, st_pkt_cnt[c*32 +: 32], exp_cnt);
        check("queue_drained", c, exp_q[c].size(), 0);
    endtask

    // Ready generator: per-channel percentage, updated just after each active edge.
    initial begin
        tx_tready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++)
                tx_tready[c] = ($urandom_range(99) < rdy_pct[c]);
        end
    end

    // Monitor: scoreboard pops, AXI-S hold checks, idle tkeep checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) prev_stall[c] = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin : mon
                logic              dv, dl;
                logic [DATA_W-1:0] dd;
                logic [BYTES-1:0]  dk;
                beat_t             e;
                dv = tx_tvalid[c];
                dl = tx_tlast[c];
                dd = tx_tdata[c*DATA_W +: DATA_W];
                dk = tx_tkeep[c*BYTES +: BYTES];
                if (prev_stall[c]) check("axis_hold", c, {dv, dd, dk, dl}, prev_vec[c]);
                if (!dv) check("idle_keep_last", c, {dk, dl}, '0);
                if (dv && tx_tready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat ch%0d: got data %0h with no beat expected", c, dd);
                    end else begin
                        e = exp_q[c].pop_front();
                        check("beat", c, {dd, dk, dl}, {e.data, e.keep, e.last});
                        byte_cnt[c] += $countones(dk);
                        if (dl) begin
                            check("pkt_bytes", c, byte_cnt[c], e.plen);
                            byte_cnt[c] = 0;
                            m_sent[c]++;
                            if ((m_num[c] != 0 && m_sent[c] == m_num[c]) || m_stop[c])
                                m_active[c] = 1'b0;
                            else
                                push_pkt(c);
                        end
                    end
                end
                prev_stall[c] = dv && !tx_tready[c];
                prev_vec[c]   = {dv, dd, dk, dl};
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 32, 1'b0, 1'b0, 'h42, 100, -1, 32, 2000};   // fixed, full rate
        vecs[1] = '{0, 32, 1'b0, 1'b0, 'h42, 50,  -1, 32, 4000};   // same with stalls
        vecs[2] = '{0, 40, 1'b1, 1'b1, 1500, 70,  -1, 40, 20000};  // random len/data
        vecs[3] = '{0, 0,  1'b0, 1'b0, 10,   80,  5,  6,  2000};   // continuous + stop
        vecs[4] = '{0, 3,  1'b0, 1'b1, 'h41, 100, -1, 3,  500};    // random data, odd tail

        cfg_start = '0; cfg_stop = '0; cfg_len_type = '0; cfg_pattern = '0;
        cfg_num_pkt = '0; cfg_pkt_len = '0;
        for (int c = 0; c < NUM_CH; c++) rdy_pct[c] = 100;
        model_reset();

        cyc(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tvalid", 0, tx_tvalid, '0);
        check("rst_tdata", 0, tx_tdata, '0);
        check("rst_tkeep", 0, tx_tkeep, '0);
        check("rst_tlast", 0, tx_tlast, '0);
        check("rst_busy", 0, st_busy, '0);
        check("rst_done", 0, st_done, '0);
        check("rst_pkt_cnt", 0, st_pkt_cnt, '0);
        @(posedge clk);
        #1;

        // Start-to-first-valid latency on ch3
        set_cfg(3, 1, 1'b0, 1'b0, 64);
        cfg_start[3] = 1'b1;
        model_start(3, 1, 1'b0, 1'b0, 64);
        @(posedge clk);
        #1;
        cfg_start[3] = 1'b0;
        @(negedge clk);
        check("load_tvalid", 3, tx_tvalid[3], 1'b0);
        check("load_busy", 3, st_busy[3], 1'b1);
        @(negedge clk);
        check("first_tvalid", 3, tx_tvalid[3], 1'b1);
        @(posedge clk);
        #1;
        wait_done(3, 100, 1);

        for (int i = 0; i < 5; i++) begin
            rdy_pct[vecs[i].ch] = vecs[i].rdy;
            drive_start(vecs[i].ch, vecs[i].num, vecs[i].lt, vecs[i].pat, vecs[i].len);
            if (vecs[i].stop_at >= 0) begin
                int k = 0;
                while (m_sent[vecs[i].ch] < int'(vecs[i].stop_at) && k < vecs[i].budget) begin
                    cyc(1);
                    k++;
                end
                if (k >= vecs[i].budget) begin
                    n_checks++;
                    $display("FAIL stop_wait ch%0d: got %0d packets expected %0d", vecs[i].ch,
                             m_sent[vecs[i].ch], vecs[i].stop_at);
                end
                cyc(3);
                cfg_stop[vecs[i].ch] = 1'b1;
                m_stop[vecs[i].ch]   = 1'b1;
                cyc(1);
                cfg_stop[vecs[i].ch] = 1'b0;
            end
            wait_done(vecs[i].ch, vecs[i].budget, vecs[i].exp_cnt);
        end
        rdy_pct[0] = 100;

        // Start and stop together from IDLE: stop is dropped
        set_cfg(1, 2, 1'b0, 1'b0, 64);
        cfg_start[1] = 1'b1;
        cfg_stop[1]  = 1'b1;
        model_start(1, 2, 1'b0, 1'b0, 64);
        cyc(1);
        cfg_start[1] = 1'b0;
        cfg_stop[1]  = 1'b0;
        wait_done(1, 200, 2);

        // Four channels concurrently, mixed modes, independent ready
        rdy_pct[0] = 60; rdy_pct[1] = 90; rdy_pct[2] = 40; rdy_pct[3] = 75;
        drive_start(0, 5, 1'b0, 1'b0, 100);
        drive_start(1, 6, 1'b1, 1'b1, 300);
        drive_start(2, 4, 1'b0, 1'b1, 'h41);
        drive_start(3, 3, 1'b1, 1'b0, 2000);
        cyc(5);
        check("busy_before_restart", 2, st_busy[2], 1'b1);
        drive_start(2, 9, 1'b1, 1'b0, 777);
        wait_done(0, 3000, 5);
        wait_done(1, 3000, 6);
        wait_done(2, 3000, 4);
        wait_done(3, 3000, 3);

        // Reset in the middle of a packet
        for (int c = 0; c < NUM_CH; c++) rdy_pct[c] = 100;
        drive_start(0, 4, 1'b0, 1'b0, 200);
        cyc(10);
        check("pre_reset_tvalid", 0, tx_tvalid[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_tvalid", 0, tx_tvalid, '0);
        check("reset_tkeep", 0, tx_tkeep, '0);
        check("reset_busy", 0, st_busy, '0);
        check("reset_pkt_cnt", 0, st_pkt_cnt, '0);
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        drive_start(0, 2, 1'b0, 1'b0, 'h42);
        wait_done(0, 200, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
